// File: rtl/mac_vlg_tx_arb.sv
// mac_vlg_tx_arb: round-robin arbiter/sequencer sharing one mac_vlg TX port among N protocol engines
package mac_vlg_pkg;
    typedef struct packed {
        logic [47:0] dst_mac_addr;
        logic [15:0] ethertype;
    } mac_hdr_t;
endpackage

module mac_vlg_tx_arb
    import mac_vlg_pkg::*;
#(
    parameter int N          = 4,
    parameter int IFG_CYCLES = 12,
    parameter int TMO_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         i_req_avl,
    input  mac_hdr_t [N-1:0]     i_req_hdr,
    input  logic [N-1:0][7:0]    i_req_d,
    input  logic [N-1:0]         i_req_v,
    output logic [N-1:0]         o_req_rdy,
    output logic [N-1:0]         o_req_done,
    output logic                 o_req_err,
    output logic                 o_mac_avl,
    input  logic                 i_mac_rdy,
    output mac_hdr_t             o_mac_hdr,
    output logic [7:0]           o_mac_d,
    output logic                 o_mac_v,
    input  logic                 i_mac_done,
    output logic [$clog2(N)-1:0] o_grant_id,
    output logic                 o_idle
);
    localparam int GW = $clog2(N);
    localparam int IW = $clog2(IFG_CYCLES + 1);
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_HDR, S_DATA, S_TAIL, S_GAP} state_t;

    state_t        r_state;
    logic [GW-1:0] r_last;
    logic [GW-1:0] r_grant;
    mac_hdr_t      r_hdr;
    logic          r_avl;
    logic [N-1:0]  r_rdy;
    logic [N-1:0]  r_done;
    logic          r_err;
    logic [7:0]    r_d;
    logic          r_v;
    logic          r_seen;
    logic [TW-1:0] r_wdt;
    logic [IW-1:0] r_ifg;

    logic          w_found;
    logic [GW-1:0] w_pick;
    logic [GW-1:0] w_ix;
    logic          w_tmo;

    assign w_tmo      = (r_wdt == TMO_LAST);
    assign o_req_rdy  = r_rdy;
    assign o_req_done = r_done;
    assign o_req_err  = r_err;
    assign o_mac_avl  = r_avl;
    assign o_mac_hdr  = r_hdr;
    assign o_mac_d    = r_d;
    assign o_mac_v    = r_v;
    assign o_grant_id = r_grant;
    assign o_idle     = (r_state == S_IDLE);

    // Round-robin search: the pending requester closest after the last grant wins
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_ix    = '0;
        for (int k = N; k >= 1; k--) begin
            w_ix = GW'((int'(r_last) + k) % N);
            if (i_req_avl[w_ix]) begin
                w_found = 1'b1;
                w_pick  = w_ix;
            end
        end
    end

    // Sequencer: grant, header handshake, payload forwarding, completion wait, watchdog and gap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= GW'(N - 1);
            r_grant <= '0;
            r_hdr   <= '0;
            r_avl   <= 1'b0;
            r_rdy   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_d     <= '0;
            r_v     <= 1'b0;
            r_seen  <= 1'b0;
            r_wdt   <= '0;
            r_ifg   <= '0;
        end else begin
            r_rdy  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            r_d    <= '0;
            r_v    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_hdr   <= i_req_hdr[w_pick];
                        r_avl   <= 1'b1;
                        r_wdt   <= '0;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (i_mac_rdy) begin
                        r_avl   <= 1'b0;
                        r_wdt   <= '0;
                        r_state <= S_HDR;
                    end else if (w_tmo) begin
                        r_done[r_grant] <= 1'b1;
                        r_err   <= 1'b1;
                        r_avl   <= 1'b0;
                        r_ifg   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_wdt <= r_wdt + 1'b1;
                    end
                end
                S_HDR: begin
                    if (!i_mac_rdy) begin
                        r_rdy[r_grant] <= 1'b1;
                        r_seen  <= 1'b0;
                        r_state <= S_DATA;
                    end else if (w_tmo) begin
                        r_done[r_grant] <= 1'b1;
                        r_err   <= 1'b1;
                        r_ifg   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_wdt <= r_wdt + 1'b1;
                    end
                end
                S_DATA: begin
                    r_d <= i_req_d[r_grant];
                    r_v <= i_req_v[r_grant];
                    if (i_req_v[r_grant]) begin
                        r_seen <= 1'b1;
                    end else if (r_seen) begin
                        if (i_mac_done) begin
                            r_done[r_grant] <= 1'b1;
                            r_ifg   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_wdt   <= '0;
                            r_state <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (i_mac_done) begin
                        r_done[r_grant] <= 1'b1;
                        r_ifg   <= '0;
                        r_state <= S_GAP;
                    end else if (w_tmo) begin
                        r_done[r_grant] <= 1'b1;
                        r_err   <= 1'b1;
                        r_ifg   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_wdt <= r_wdt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_ifg == IFG_LAST) begin
                        r_hdr   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ifg <= r_ifg + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
